// File: rtl/tic_tac_pkg.sv
// rtl/tic_tac_pkg.sv - shared cell/state encodings, line table and board helpers
package tic_tac_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HUMAN = 2'b01,
    COMP  = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    HWIN  = 3'd1,
    CWIN  = 3'd2,
    DRAW  = 3'd3,
    ERROR = 3'd4
  } game_state_t;

  // Rows, columns, diagonals; squares numbered row-major from 1 at top-left.
  localparam logic [3:0] LINE_TBL [0:7][0:2] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  function automatic logic in_range(input logic [3:0] sq);
    return (sq >= 4'd1) && (sq <= 4'd9);
  endfunction

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] sq);
    logic [1:0] c;
    c = EMPTY;
    for (int k = 1; k <= 9; k++) begin
      if (sq == 4'(k)) c = b[2*k-2 +: 2];
    end
    return c;
  endfunction

  function automatic logic [17:0] put_mark(input logic [17:0] b, input logic [3:0] sq,
                                           input cell_t who);
    logic [17:0] r;
    r = b;
    for (int k = 1; k <= 9; k++) begin
      if (sq == 4'(k)) r[2*k-2 +: 2] = who;
    end
    return r;
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (b[2*k-2 +: 2] == EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/tic_tac_referee_line_check.sv
// rtl/tic_tac_referee_line_check.sv - reports whether a player owns any of the 8 lines
module tic_tac_line_check
  import tic_tac_pkg::*;
(
  input  logic [17:0] i_board,
  input  cell_t       i_player,
  output logic        o_owns
);

  always_comb begin
    o_owns = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((cell_at(i_board, LINE_TBL[l][0]) == i_player) &&
          (cell_at(i_board, LINE_TBL[l][1]) == i_player) &&
          (cell_at(i_board, LINE_TBL[l][2]) == i_player))
        o_owns = 1'b1;
    end
  end

endmodule

// File: rtl/tic_tac_referee.sv
// rtl/tic_tac_referee.sv - tic-tac-toe referee: validates one human+computer round per step
module tic_tac_referee
  import tic_tac_pkg::*;
#(
  parameter int CHECK_WIN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        newGame,
  input  logic        step,
  input  logic [3:0]  hMove,
  input  logic [3:0]  cMove,
  input  logic        win,
  output logic [17:0] board,
  output logic [3:0]  moveCount,
  output logic [2:0]  gameState,
  output logic        gameOver,
  output logic [3:0]  errSquare,
  output logic        winMismatch
);

  logic [17:0]  r_board;
  logic [3:0]   r_count;
  game_state_t  r_state;
  logic         r_over;
  logic [3:0]   r_err;
  logic         r_mm;

  logic         w_h_ok;
  logic         w_c_req;
  logic         w_c_ok;
  logic [17:0]  w_h_board;
  logic [17:0]  w_next_board;
  logic [1:0]   w_placed;
  logic         w_err;
  logic [3:0]   w_err_sq;
  logic         w_h_line;
  logic         w_c_line;
  logic [4:0]   w_sum;
  logic [3:0]   w_next_count;
  game_state_t  w_next_state;
  logic         w_mm_hit;

  assign w_h_ok    = in_range(hMove) && (cell_at(r_board, hMove) == EMPTY);
  assign w_c_req   = (cMove != 4'd0);
  // cMove != hMove makes the original board a valid emptiness check for the reply.
  assign w_c_ok    = in_range(cMove) && (cell_at(r_board, cMove) == EMPTY) && (cMove != hMove);
  assign w_h_board = put_mark(r_board, hMove, HUMAN);

  always_comb begin
    w_next_board = r_board;
    w_placed     = 2'd0;
    w_err        = 1'b0;
    w_err_sq     = 4'd0;
    if (!w_h_ok) begin
      w_err    = 1'b1;
      w_err_sq = hMove;
    end else begin
      w_next_board = w_h_board;
      w_placed     = 2'd1;
      if (w_c_req && !w_c_ok) begin
        w_err    = 1'b1;
        w_err_sq = cMove;
      end else if (w_c_req) begin
        w_next_board = put_mark(w_h_board, cMove, COMP);
        w_placed     = 2'd2;
      end
    end
  end

  tic_tac_line_check u_human_line (
    .i_board  (w_next_board),
    .i_player (HUMAN),
    .o_owns   (w_h_line)
  );

  tic_tac_line_check u_comp_line (
    .i_board  (w_next_board),
    .i_player (COMP),
    .o_owns   (w_c_line)
  );

  assign w_sum        = {1'b0, r_count} + {3'b000, w_placed};
  assign w_next_count = (w_sum > 5'd9) ? 4'd9 : w_sum[3:0];
  assign w_mm_hit     = (CHECK_WIN != 0) && (win != w_c_line);

  always_comb begin
    w_next_state = PLAY;
    if (w_err)                       w_next_state = ERROR;
    else if (w_c_line)               w_next_state = CWIN;
    else if (w_h_line)               w_next_state = HWIN;
    else if (board_full(w_next_board)) w_next_state = DRAW;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_board <= '0;
      r_count <= '0;
      r_state <= PLAY;
      r_over  <= 1'b0;
      r_err   <= '0;
      r_mm    <= 1'b0;
    end else if (newGame) begin
      r_board <= '0;
      r_count <= '0;
      r_state <= PLAY;
      r_over  <= 1'b0;
      r_err   <= '0;
      r_mm    <= 1'b0;
    end else if (step && (r_state == PLAY)) begin
      r_board <= w_next_board;
      r_count <= w_next_count;
      r_state <= w_next_state;
      r_over  <= (w_next_state != PLAY);
      if (w_err)    r_err <= w_err_sq;
      if (w_mm_hit) r_mm  <= 1'b1;
    end
  end

  assign board       = r_board;
  assign moveCount   = r_count;
  assign gameState   = r_state;
  assign gameOver    = r_over;
  assign errSquare   = r_err;
  assign winMismatch = r_mm;

endmodule

// File: doc/tic_tac_referee.md
TIC_TAC_REFEREE -- requirements
Module: tic_tac_referee

Interface
REQ-001 Parameter CHECK_WIN, default 1, meaning: 1 enables the winMismatch cross-check against the win input; 0 ties winMismatch to 0.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 newGame  input  1  synchronous clear of board and status; has priority over step.
REQ-005 step  input  1  one-cycle strobe; hMove/cMove/win for one round are valid this cycle.
REQ-006 hMove  input  4  human square, 1..9 legal; 0 and 10..15 illegal.
REQ-007 cMove  input  4  computer reply square, 1..9 legal; 0 means no reply this round.
REQ-008 win  input  1  upstream game FSM's computer-win claim.
REQ-009 board  output  18  cell k (1..9) at bits [2k-1:2k-2]; encoding 00 empty, 01 human, 10 computer.
REQ-010 moveCount  output  4  marks placed, 0..9.
REQ-011 gameState  output  3  PLAY, HWIN, CWIN, DRAW or ERROR.
REQ-012 gameOver  output  1  high in every state except PLAY.
REQ-013 errSquare  output  4  offending square latched on entry to ERROR; 0 otherwise.
REQ-014 winMismatch  output  1  sticky; win claim disagrees with the board.

Function
REQ-015 step SHALL be ignored when gameState is not PLAY; board, moveCount and status SHALL then hold.
REQ-016 On step in PLAY, the human mark SHALL be evaluated first and the computer mark second, both in the same cycle; the results SHALL be visible on outputs the next cycle (1-cycle latency).
REQ-017 Illegal hMove (out of range or cell not empty): board and moveCount SHALL be unchanged, gameState goes to ERROR, errSquare = hMove.
REQ-018 Illegal nonzero cMove (out of range, cell not empty, or cMove == hMove): the human mark SHALL still be applied, the computer mark SHALL NOT be applied, gameState goes to ERROR, errSquare = cMove.
REQ-019 Legal marks SHALL be written; moveCount SHALL increase by the number written (0, 1 or 2) and saturate at 9.
REQ-020 Next-state priority, evaluated on the updated board: ERROR > CWIN (computer owns a line) > HWIN (human owns a line) > DRAW (all 9 cells non-empty) > PLAY.
REQ-021 Lines SHALL be the 3 rows, 3 columns and 2 diagonals; cells are numbered row-major, 1 at top-left.
REQ-022 If the human completes a line, a legal cMove in the same step SHALL still be written; the state is CWIN only if the computer also completes a line.
REQ-023 With CHECK_WIN = 1: on an accepted step, winMismatch SHALL set if win differs from "computer owns a line" on the updated board. It SHALL clear only on reset or newGame.
REQ-024 HWIN, CWIN, DRAW and ERROR SHALL be terminal until newGame or reset.
REQ-025 newGame together with step: newGame wins; the step is discarded.

Reset
REQ-026 While reset is asserted, the block SHALL immediately hold: board = 0, moveCount = 0, gameState = PLAY, errSquare = 0, winMismatch = 0. The same values SHALL follow newGame on the next edge.
REQ-027 Reset asserted mid-round SHALL abandon the round with no partial board update.

Structure
REQ-028 A shared package tic_tac_pkg SHALL hold the cell enum (EMPTY, HUMAN, COMP), the gameState enum, and the 8 line triplets as a constant table.
REQ-029 Sub-module tic_tac_line_check SHALL take the 18-bit board and a player code and return 1 if that player owns any line; it is instantiated twice (human, computer).

Verification
REQ-030 reset; step hMove=5 cMove=1 win=0 -> board cell5=01, cell1=10, moveCount=2, PLAY, gameOver=0.
REQ-031 Steps (1,4) (2,7) (9,0)... human on 1,2 then step hMove=3 cMove=0 -> HWIN, gameOver=1; a further step leaves the board unchanged.
REQ-032 Computer on 1,2 then step hMove=9 cMove=3 win=1 -> CWIN, winMismatch=0; repeat with win=0 -> winMismatch=1, and it stays 1 until newGame.
REQ-033 Step hMove=5 when cell5 is occupied -> ERROR, errSquare=5, board unchanged. Step hMove=4 cMove=4 -> cell4=01, ERROR, errSquare=4. hMove=12 -> ERROR, errSquare=12.
REQ-034 Play a 9-mark sequence with no line -> DRAW, moveCount=9. newGame with step in the same cycle -> board=0, PLAY. Reset asserted between edges -> outputs clear at once, without waiting for a clock edge.
